scan_decoder: RTL and testbench

Parametrised, registered successor to the team's 3-to-8 active-low decoder: decodes an SEL_W-bit index onto 2^SEL_W active-low select lines, gated by the same three-input enable (G1 high, G2/G3 low). In addition to direct decoding of a loaded address, it has a scan mode: an internal prescaled counter steps the index automatically. Scan mode drives digit/row selects of multiplexed seven-segment displays and LED matrices on the lab board.

---
 rtl/scan_decoder_pkg.sv | 22 ++
 rtl/scan_decoder_if.sv | 30 +++
 rtl/scan_tick.sv | 30 +++
 rtl/scan_decoder.sv | 75 +++++++
 tb/tb_scan_decoder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared constants and helpers for the scan_decoder block.
// Mode encodings plus the active-low one-hot pattern generator used by the decode stage.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned MAX_SEL_W = 6;
    localparam int unsigned MAX_N     = 1 << MAX_SEL_W;

    // Active-low one-hot: only bit idx is low; an out-of-range idx yields all ones.
    function automatic logic [MAX_N-1:0] onehot_n(input logic [MAX_SEL_W-1:0] idx,
                                                  input int unsigned          width);
        logic [MAX_N-1:0] pat;
        pat = '1;
        if (32'(idx) < width) begin
            pat[idx] = 1'b0;
        end
        return pat;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/data bundle between a scan_decoder and whatever drives it.
// The master side supplies enables, mode and addressing; the slave side returns the decoded selects.
interface scan_decoder_if #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DIV_W = 16
);
    localparam int unsigned N = 1 << SEL_W;

    logic             g1;
    logic             not_g2;
    logic             not_g3;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     not_y;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output g1, not_g2, not_g3, mode, load, sel, div,
        input  not_y, idx, wrap
    );

    modport slave (
        input  g1, not_g2, not_g3, mode, load, sel, div,
        output not_y, idx, wrap
    );

endinterface

// File: rtl/scan_tick.sv
// Dwell prescaler for scan mode: counts 0..div while running and flags the step cycle.
// tick is combinational so the index can advance on the same edge the count is reached.
module scan_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so lowering div below the running count steps immediately.
    assign tick = run && (cnt >= div);

    // Holding (not clearing) while stopped lets a paused dwell resume where it left off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered, enable-gated active-low N-way decoder with direct-load and auto-scan indexing.
// idx, not_y and wrap all come straight from flops, so the selects are glitch-free.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DIV_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    scan_decoder_if.slave bus
);

    localparam int unsigned N = 1 << SEL_W;

    logic             en;
    logic             scan;
    logic             tick;
    logic             step;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_next;
    logic [N-1:0]     not_y_q;
    logic [N-1:0]     not_y_next;
    logic             wrap_q;
    logic             wrap_next;

    assign en   = bus.g1 & ~bus.not_g2 & ~bus.not_g3;
    assign scan = (bus.mode == MODE_SCAN);
    assign step = en & scan & tick;

    // Prescaler sits at zero in direct mode so a switch to scan starts a full dwell.
    scan_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (en & scan),
        .clr  (~scan),
        .div  (bus.div),
        .tick (tick)
    );

    // Next index first, then decode from it so not_y and idx always agree.
    always_comb begin
        idx_next   = idx_q;
        wrap_next  = 1'b0;
        not_y_next = '1;
        if (step) begin
            idx_next  = idx_q + SEL_W'(1);
            wrap_next = (idx_q == SEL_W'(N - 1));
        end else if (en && !scan && bus.load) begin
            idx_next = bus.sel;
        end
        if (en) begin
            not_y_next = N'(onehot_n(MAX_SEL_W'(idx_next), N));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            not_y_q <= '1;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_next;
            not_y_q <= not_y_next;
            wrap_q  <= wrap_next;
        end
    end

    assign bus.idx   = idx_q;
    assign bus.not_y = not_y_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: an 8-way and a 16-way instance share clock and reset.
// Stimulus queues the expected outputs per cycle; a negedge monitor pops and compares them.
module tb_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    scan_decoder_if #(.SEL_W(3), .DIV_W(16)) bus3 ();
    scan_decoder_if #(.SEL_W(4), .DIV_W(16)) bus4 ();

    scan_decoder #(.SEL_W(3), .DIV_W(16)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    scan_decoder #(.SEL_W(4), .DIV_W(16)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    typedef struct {
        int          cyc;
        bit          wide;
        logic [15:0] not_y;
        logic [3:0]  idx;
        logic        wrap;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc         = 0;
    int   applied     = 0;
    int   miscompares = 0;
    logic [7:0] walk [8];

    always @(posedge clk) cyc++;

    task automatic push(input int at, input bit wide, input logic [15:0] ny,
                        input logic [3:0] ix, input logic w, input string tag);
        exp_t e;
        e.cyc = at; e.wide = wide; e.not_y = ny; e.idx = ix; e.wrap = w; e.tag = tag;
        q.push_back(e);
    endtask

    // Expectation for the 8-way instance after the coming clock edge.
    task automatic exp3(input logic [7:0] ny, input logic [2:0] ix, input logic w, input string tag);
        push(cyc + 1, 1'b0, {8'h00, ny}, {1'b0, ix}, w, tag);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Async assert just after an edge, checked before the next edge; then one edge in reset.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(cyc, 1'b0, 16'h00FF, 4'd0, 1'b0, {tag, "_async3"});
        push(cyc, 1'b1, 16'hFFFF, 4'd0, 1'b0, {tag, "_async4"});
        @(negedge clk);
        exp3(8'hFF, 3'd0, 1'b0, {tag, "_held"});
        tick();
        rst      = 1'b0;
        bus3.g1  = 1'b0;
        exp3(8'hFF, 3'd0, 1'b0, {tag, "_released"});
        tick();
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [15:0] a_ny;
        logic [3:0]  a_ix;
        logic        a_w;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.wide) begin
                a_ny = bus4.not_y;
                a_ix = bus4.idx;
                a_w  = bus4.wrap;
            end else begin
                a_ny = {8'h00, bus3.not_y};
                a_ix = {1'b0, bus3.idx};
                a_w  = bus3.wrap;
            end
            applied++;
            if (e.cyc != cyc || a_ny !== e.not_y || a_ix !== e.idx || a_w !== e.wrap) begin
                miscompares++;
                $display("FAIL %s cyc=%0d (due %0d): got not_y=%h idx=%0d wrap=%b, want not_y=%h idx=%0d wrap=%b",
                         e.tag, cyc, e.cyc, a_ny, a_ix, a_w, e.not_y, e.idx, e.wrap);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          ix;
        logic [15:0] one;
        walk = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        one  = 16'h0001;
        {bus3.g1, bus3.not_g2, bus3.not_g3, bus3.mode, bus3.load} = '0;
        {bus4.g1, bus4.not_g2, bus4.not_g3, bus4.mode, bus4.load} = '0;
        bus3.sel = '0; bus3.div = '0;
        bus4.sel = '0; bus4.div = '0;

        do_reset("por");

        // Direct mode load, hold and enable gating.
        bus3.g1 = 1'b1; bus3.mode = 1'b0; bus3.load = 1'b1; bus3.sel = 3'd3;
        exp3(8'hF7, 3'd3, 1'b0, "load3"); tick();
        bus3.load = 1'b0; bus3.sel = 3'd5;
        exp3(8'hF7, 3'd3, 1'b0, "direct_hold"); tick();
        bus3.not_g2 = 1'b1; bus3.load = 1'b1; bus3.sel = 3'd6;
        exp3(8'hFF, 3'd3, 1'b0, "g2_disable"); tick();
        bus3.not_g2 = 1'b0; bus3.load = 1'b0;
        exp3(8'hF7, 3'd3, 1'b0, "g2_enable"); tick();
        bus3.not_g3 = 1'b1;
        exp3(8'hFF, 3'd3, 1'b0, "g3_disable"); tick();
        bus3.not_g3 = 1'b0;

        // Scan with div=2 from idx 0; load held high must be ignored.
        bus3.load = 1'b1; bus3.sel = 3'd0;
        exp3(8'hFE, 3'd0, 1'b0, "load0"); tick();
        bus3.mode = 1'b1; bus3.div = 16'd2; bus3.sel = 3'd7;
        for (int k = 1; k <= 26; k++) begin
            exp3(walk[(k / 3) % 8], 3'((k / 3) % 8), k == 24, "scan_div2");
            tick();
        end

        // div=0 steps every clock; a 5-cycle enable drop freezes idx without skipping.
        bus3.div = 16'd0; bus3.load = 1'b0;
        ix = 0;
        for (int j = 1; j <= 10; j++) begin
            ix = (ix + 1) % 8;
            exp3(walk[ix], 3'(ix), ix == 0, "scan_div0"); tick();
        end
        bus3.g1 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            exp3(8'hFF, 3'(ix), 1'b0, "g1_drop"); tick();
        end
        bus3.g1 = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            ix = (ix + 1) % 8;
            exp3(walk[ix], 3'(ix), ix == 0, "g1_resume"); tick();
        end

        // Lower div from 10 to 1 with the prescaler at 6.
        bus3.mode = 1'b0;
        exp3(walk[1], 3'd1, 1'b0, "to_direct"); tick();
        bus3.mode = 1'b1; bus3.div = 16'd10;
        for (int k = 0; k < 6; k++) begin
            exp3(walk[1], 3'd1, 1'b0, "div10_dwell"); tick();
        end
        bus3.div = 16'd1;
        for (int k = 0; k < 5; k++) begin
            exp3(walk[2 + k / 2], 3'(2 + k / 2), 1'b0, "div_lowered"); tick();
        end

        // Scan -> direct holds idx; direct -> scan starts a fresh dwell.
        bus3.mode = 1'b0;
        exp3(walk[4], 3'd4, 1'b0, "scan_to_direct"); tick();
        bus3.mode = 1'b1;
        exp3(walk[4], 3'd4, 1'b0, "direct_to_scan"); tick();
        exp3(walk[5], 3'd5, 1'b0, "first_step"); tick();

        // Enable drop mid-dwell (div=3): remaining count resumes afterwards.
        bus3.div = 16'd3;
        exp3(walk[5], 3'd5, 1'b0, "dwell_a"); tick();
        bus3.g1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp3(8'hFF, 3'd5, 1'b0, "dwell_paused"); tick();
        end
        bus3.g1 = 1'b1;
        exp3(walk[5], 3'd5, 1'b0, "dwell_b"); tick();
        exp3(walk[5], 3'd5, 1'b0, "dwell_c"); tick();
        exp3(walk[6], 3'd6, 1'b0, "dwell_step"); tick();

        do_reset("midscan");

        // 16-way instance: div=0 scan, sixteen distinct patterns, wrap every 16 clocks.
        bus4.g1 = 1'b1; bus4.mode = 1'b1; bus4.div = 16'd0;
        for (int k = 1; k <= 33; k++) begin
            push(cyc + 1, 1'b1, ~(one << (k % 16)), 4'(k % 16), (k == 16) || (k == 32), "scan16");
            tick();
        end

        tick();
        tick();
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL pending: %0d expectations never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
